uart_rx_os16: RTL and testbench
===============================

UART_RX_OS16 -- requirements
Module: uart_rx_os16

Interface
REQ-001 Parameter CLK_DIV, default 4: clk_i cycles per oversample tick (>=1); bit period = 16*CLK_DIV clocks.
REQ-002 Parameter DATA_BITS, default 8: data bits per frame (5..8), LSB first, no parity, 1 stop bit.
REQ-003 clk_i  input  1  single clock; every flop on the rising edge.
REQ-004 rst_n_i  input  1  reset, asynchronous and active-low.
REQ-005 RxD_i  input  1  serial line, idle high, asynchronous to clk_i.
REQ-006 data_o  output  DATA_BITS  last good received byte.
REQ-007 valid_o  output  1  data_o holds an unconsumed byte.
REQ-008 ready_i  input  1  consumer accepts data_o when valid_o && ready_i.
REQ-009 frame_err_o  output  1  one-clock pulse: stop bit sampled low.
REQ-010 overrun_o  output  1  one-clock pulse: new byte lost, holding register full.
REQ-011 busy_o  output  1  high in every state except IDLE.

Function
REQ-012 RxD_i SHALL pass a 2-flop synchronizer (reset value 1) before any use.
REQ-013 Tick counter SHALL emit a one-clock enable every CLK_DIV clocks, free-running; all oversample counting uses only this enable.
REQ-014 FSM states SHALL be IDLE, START, DATA, STOP, BREAK; all outside IDLE use a 4-bit tick count (0..15) that wraps 15->0.
REQ-015 IDLE -> START on a synced 1->0 transition; tick count cleared to 0.
REQ-016 START: at tick count 7, line low -> DATA (bit index 0, count cleared); line high -> IDLE (glitch rejected, no output).
REQ-017 DATA: sample at every 16th tick after the previous sample, shift into the shift register LSB first; after bit DATA_BITS-1 -> STOP.
REQ-018 STOP: sample 16 ticks after the last data bit; high -> frame good, -> IDLE; low -> frame_err_o pulse, byte discarded, -> BREAK.
REQ-019 BREAK: remain until synced line is high, then -> IDLE; no start detection in BREAK.
REQ-020 Good frame: data_o loaded and valid_o set on the clock after the stop sample.
REQ-021 valid_o SHALL clear on the clock after valid_o && ready_i, unless a new byte loads that same clock.
REQ-022 Good frame with valid_o high and ready_i low: data_o unchanged, valid_o stays high, overrun_o pulses one clock.
REQ-023 Good frame with valid_o && ready_i in the same clock: new byte loads, valid_o stays high, no overrun.
REQ-024 data_o SHALL stay stable while valid_o is high, except per REQ-023.
REQ-025 A new start edge in the clock right after a good stop SHALL be accepted (back-to-back frames).

Reset
REQ-026 rst_n_i low SHALL immediately force: FSM IDLE, counters 0, synchronizer 1, data_o 0, valid_o 0, frame_err_o 0, overrun_o 0, busy_o 0.
REQ-027 Reset mid-frame SHALL discard the partial byte; the first start edge after release begins a clean frame.

Structure
REQ-028 Shared package uart_pkg SHALL hold the FSM state type, OS_RATE=16 and MID_TICK=7 constants.
REQ-029 One sub-module uart_os_tick (counter -> one-clock enable, parameter CLK_DIV) SHALL be instantiated; the rest stays in one module.

Verification (CLK_DIV=4, 64-clock bit period, 20 ns clock)
REQ-030 Frame 0xA5, ready_i low -> valid_o rises about 9.5 bit periods after the start edge (+/-2 clocks sync), data_o=0xA5, busy_o low after that.
REQ-031 RxD_i low for 20 clocks, then high -> no valid_o, no frame_err_o, busy_o back low before tick count 8 expires.
REQ-032 Frame 0x3C with stop bit low, then line high after 2 bit periods -> one frame_err_o pulse, valid_o stays 0, the next frame 0x81 is received correctly.
REQ-033 Back-to-back 0x12, 0x34, ready_i held low -> data_o=0x12, one overrun_o pulse at the second frame; pulse ready_i once -> valid_o drops.
REQ-034 ready_i asserted on the exact load clock of the second byte -> data_o=0x34, valid_o stays high, no overrun_o.
REQ-035 rst_n_i pulsed low during bit 4 of frame 0xFF -> all outputs 0 during reset; the following frame 0x5A gives data_o=0x5A.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the 16x-oversampling UART receiver.
//   rx_state_e : receiver FSM states
//   OS_RATE    : oversample ticks per bit
//   MID_TICK   : tick count at which the start bit is re-checked (bit centre)
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } rx_state_e;

  localparam int unsigned OS_RATE  = 16;
  localparam int unsigned MID_TICK = 7;

endpackage

// File: rtl/uart_os_tick.sv
// Free-running oversample tick generator.
//   clk_i   : clock
//   rst_n_i : asynchronous active-low reset
//   tick_o  : one-clock enable every CLK_DIV clocks
module uart_os_tick #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_n_i,
  output logic tick_o
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q  <= '0;
      tick_o <= 1'b0;
    end else if (cnt_q == CntW'(CLK_DIV - 1)) begin
      cnt_q  <= '0;
      tick_o <= 1'b1;
    end else begin
      cnt_q  <= cnt_q + CntW'(1);
      tick_o <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx_os16.sv
// UART receiver, 16x oversampling, LSB first, no parity, one stop bit.
//   clk_i       : clock
//   rst_n_i     : asynchronous active-low reset
//   RxD_i       : serial line (idle high, asynchronous)
//   data_o      : last good received byte
//   valid_o     : data_o holds an unconsumed byte
//   ready_i     : consumer accepts data_o when valid_o && ready_i
//   frame_err_o : one-clock pulse, stop bit sampled low
//   overrun_o   : one-clock pulse, good byte dropped because holding register full
//   busy_o      : receiver is not idle
module uart_rx_os16
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned DATA_BITS = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 RxD_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
);

  localparam logic [3:0] MidCnt  = 4'(MID_TICK);
  localparam logic [3:0] LastCnt = 4'(OS_RATE - 1);
  localparam logic [2:0] LastBit = 3'(DATA_BITS - 1);

  logic                 tick;
  rx_state_e            state_q;
  logic                 rxd_meta_q, rxd_sync_q, rxd_prev_q;
  logic [3:0]           tick_cnt_q;
  logic [2:0]           bit_idx_q;
  logic [DATA_BITS-1:0] shift_q;

  uart_os_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_os_tick (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .tick_o (tick)
  );

  assign busy_o = (state_q != StIdle);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= StIdle;
      rxd_meta_q  <= 1'b1;
      rxd_sync_q  <= 1'b1;
      rxd_prev_q  <= 1'b1;
      tick_cnt_q  <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      data_o      <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      rxd_meta_q  <= RxD_i;
      rxd_sync_q  <= rxd_meta_q;
      rxd_prev_q  <= rxd_sync_q;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;

      // Consumption; a load later in this block overrides the clear.
      if (valid_o && ready_i) valid_o <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (rxd_prev_q && !rxd_sync_q) begin
            state_q    <= StStart;
            tick_cnt_q <= '0;
          end
        end
        StStart: begin
          if (tick) begin
            if (tick_cnt_q == MidCnt) begin
              tick_cnt_q <= '0;
              bit_idx_q  <= '0;
              // Line back high at bit centre: treat as a glitch.
              state_q    <= rxd_sync_q ? StIdle : StData;
            end else begin
              tick_cnt_q <= tick_cnt_q + 4'd1;
            end
          end
        end
        StData: begin
          if (tick) begin
            tick_cnt_q <= tick_cnt_q + 4'd1;  // wraps 15 -> 0
            if (tick_cnt_q == LastCnt) begin
              shift_q <= {rxd_sync_q, shift_q[DATA_BITS-1:1]};
              if (bit_idx_q == LastBit) state_q <= StStop;
              else bit_idx_q <= bit_idx_q + 3'd1;
            end
          end
        end
        StStop: begin
          if (tick) begin
            tick_cnt_q <= tick_cnt_q + 4'd1;
            if (tick_cnt_q == LastCnt) begin
              if (rxd_sync_q) begin
                state_q <= StIdle;
                if (valid_o && !ready_i) begin
                  overrun_o <= 1'b1;
                end else begin
                  data_o  <= shift_q;
                  valid_o <= 1'b1;
                end
              end else begin
                frame_err_o <= 1'b1;
                state_q     <= StBreak;
              end
            end
          end
        end
        StBreak: begin
          if (rxd_sync_q) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_os16.sv
// Self-checking bench for uart_rx_os16 (CLK_DIV=4, DATA_BITS=8, 20 ns clock).
module tb_uart_rx_os16;

  localparam int BIT = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       rxd = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       valid, frame_err, overrun, busy;

  int n_cmp = 0;
  int n_err = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  logic [7:0] exp_q[$];

  uart_rx_os16 #(
    .CLK_DIV  (4),
    .DATA_BITS(8)
  ) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .RxD_i      (rxd),
    .data_o     (data),
    .valid_o    (valid),
    .ready_i    (ready),
    .frame_err_o(frame_err),
    .overrun_o  (overrun),
    .busy_o     (busy)
  );

  always #10 clk = ~clk;

  // Count clocks each pulse output is high; a single-clock pulse adds exactly 1.
  always @(negedge clk) begin
    if (frame_err === 1'b1) ferr_cnt <= ferr_cnt + 1;
    if (overrun === 1'b1) ovr_cnt <= ovr_cnt + 1;
  end

  task automatic wait_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int hold_low);
    rxd = 1'b0;
    repeat (BIT) wait_clk();
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (BIT) wait_clk();
    end
    rxd = stop;
    repeat (BIT) wait_clk();
    if (!stop) repeat (hold_low) wait_clk();
    rxd = 1'b1;
  endtask

  task automatic wait_valid(output int c);
    c = 0;
    while (valid !== 1'b1 && c < 800) begin
      wait_clk();
      c++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) wait_clk();
    n_cmp++; if (data !== 8'h00) begin n_err++; $display("FAIL reset_data got %h want 00", data); end
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", valid); end
    n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_ferr got %b want 0", frame_err); end
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL reset_ovr got %b want 0", overrun); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    rst_n = 1'b1;
    repeat (BIT) wait_clk();
  endtask

  task automatic test_good_frame();
    int c;
    logic [7:0] e;
    ready = 1'b0;
    exp_q.push_back(8'hA5);
    fork
      send_frame(8'hA5, 1'b1, 0);
      wait_valid(c);
    join
    n_cmp++; if (c < 604 || c > 616) begin n_err++; $display("FAIL good_latency got %0d want 604..616", c); end
    e = exp_q.pop_front();
    n_cmp++; if (data !== e) begin n_err++; $display("FAIL good_data got %h want %h", data, e); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL good_busy_after got %b want 0", busy); end
    n_cmp++; if (valid !== 1'b1) begin n_err++; $display("FAIL good_valid_hold got %b want 1", valid); end
    ready = 1'b1;
    wait_clk();
    ready = 1'b0;
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL good_consume got %b want 0", valid); end
  endtask

  task automatic test_glitch();
    int f0;
    logic saw_busy;
    f0 = ferr_cnt;
    saw_busy = 1'b0;
    rxd = 1'b0;
    repeat (20) begin wait_clk(); saw_busy |= busy; end
    rxd = 1'b1;
    repeat (20) begin wait_clk(); saw_busy |= busy; end
    repeat (60) wait_clk();
    n_cmp++; if (saw_busy !== 1'b1) begin n_err++; $display("FAIL glitch_busy_seen got %b want 1", saw_busy); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL glitch_busy_end got %b want 0", busy); end
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL glitch_valid got %b want 0", valid); end
    n_cmp++; if (ferr_cnt - f0 !== 0) begin n_err++; $display("FAIL glitch_ferr got %0d want 0", ferr_cnt - f0); end
  endtask

  task automatic test_frame_err();
    int f0, c;
    logic [7:0] e;
    f0 = ferr_cnt;
    fork
      send_frame(8'h3C, 1'b0, BIT);
      begin
        repeat (660) wait_clk();
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL ferr_break_busy got %b want 1", busy); end
      end
    join
    repeat (8) wait_clk();
    n_cmp++; if (ferr_cnt - f0 !== 1) begin n_err++; $display("FAIL ferr_pulses got %0d want 1", ferr_cnt - f0); end
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL ferr_valid got %b want 0", valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ferr_busy_end got %b want 0", busy); end
    repeat (BIT) wait_clk();
    exp_q.push_back(8'h81);
    fork
      send_frame(8'h81, 1'b1, 0);
      wait_valid(c);
    join
    n_cmp++; if (c >= 800) begin n_err++; $display("FAIL ferr_next_timeout got %0d want <800", c); end
    e = exp_q.pop_front();
    n_cmp++; if (data !== e) begin n_err++; $display("FAIL ferr_next_data got %h want %h", data, e); end
    ready = 1'b1;
    wait_clk();
    ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int o0;
    logic [7:0] e;
    ready = 1'b0;
    o0 = ovr_cnt;
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1, 0);
    send_frame(8'h34, 1'b1, 0);  // dropped: holding register still full
    repeat (4) wait_clk();
    e = exp_q.pop_front();
    n_cmp++; if (valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid got %b want 1", valid); end
    n_cmp++; if (data !== e) begin n_err++; $display("FAIL b2b_data got %h want %h", data, e); end
    n_cmp++; if (ovr_cnt - o0 !== 1) begin n_err++; $display("FAIL b2b_overrun got %0d want 1", ovr_cnt - o0); end
    ready = 1'b1;
    wait_clk();
    ready = 1'b0;
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL b2b_consume got %b want 0", valid); end
  endtask

  task automatic test_ready_on_load();
    int l1, o0;
    logic [7:0] e;
    ready = 1'b0;
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h34);
    fork
      send_frame(8'h12, 1'b1, 0);
      wait_valid(l1);
    join
    n_cmp++; if (l1 >= 800) begin n_err++; $display("FAIL rol_first_timeout got %0d want <800", l1); end
    e = exp_q.pop_front();
    n_cmp++; if (data !== e) begin n_err++; $display("FAIL rol_first_data got %h want %h", data, e); end
    o0 = ovr_cnt;
    // Same tick phase as the first frame, so the load lands on clock l1 again.
    fork
      send_frame(8'h34, 1'b1, 0);
      begin
        for (int k = 1; k < l1; k++) wait_clk();
        ready = 1'b1;
        wait_clk();
        ready = 1'b0;
      end
    join
    repeat (4) wait_clk();
    e = exp_q.pop_front();
    n_cmp++; if (data !== e) begin n_err++; $display("FAIL rol_data got %h want %h", data, e); end
    n_cmp++; if (valid !== 1'b1) begin n_err++; $display("FAIL rol_valid got %b want 1", valid); end
    n_cmp++; if (ovr_cnt - o0 !== 0) begin n_err++; $display("FAIL rol_overrun got %0d want 0", ovr_cnt - o0); end
  endtask

  task automatic test_reset_mid_frame();
    int f0, c;
    logic [7:0] e;
    fork
      send_frame(8'hFF, 1'b1, 0);
      begin
        repeat (BIT * 5 + 32) wait_clk();
        rst_n = 1'b0;
        #2;
        n_cmp++; if (data !== 8'h00) begin n_err++; $display("FAIL rmid_data got %h want 00", data); end
        n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL rmid_valid got %b want 0", valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy got %b want 0", busy); end
        n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL rmid_ferr got %b want 0", frame_err); end
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL rmid_ovr got %b want 0", overrun); end
        repeat (3) wait_clk();
        rst_n = 1'b1;
      end
    join
    f0 = ferr_cnt;
    repeat (BIT) wait_clk();
    exp_q.push_back(8'h5A);
    fork
      send_frame(8'h5A, 1'b1, 0);
      wait_valid(c);
    join
    n_cmp++; if (c >= 800) begin n_err++; $display("FAIL rmid_next_timeout got %0d want <800", c); end
    e = exp_q.pop_front();
    n_cmp++; if (data !== e) begin n_err++; $display("FAIL rmid_next_data got %h want %h", data, e); end
    n_cmp++; if (ferr_cnt - f0 !== 0) begin n_err++; $display("FAIL rmid_ferr_cnt got %0d want 0", ferr_cnt - f0); end
  endtask

  initial begin
    #5;
    test_reset();
    test_good_frame();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_ready_on_load();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
